pc_ir_fetch: RTL and testbench

Instruction-fetch front end of the multi-cycle CPU. Holds the program counter and drives `InsAddr`/`InsMemRW` into `Instruction_Memory`. Latches the returned `readIns` into the instruction register (IR) under control-unit strobes and splits the IR into decode fields. Computes the next PC for sequential, branch, jump and register-jump flow, and freezes the front end on a `halt` opcode.

---
 rtl/pc_ir_fetch.sv | 150 +++++++++++++++
 tb/tb_pc_ir_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_fetch.sv
// pc_ir_fetch: instruction-fetch front end of the multi-cycle CPU.
// Holds the PC and the instruction register, splits the IR into decode
// fields, selects the next PC (sequential / branch / jump / register) and
// freezes fetch once a halt opcode has been captured.
// Optional feature macro: PC_IR_FETCH_CNT_EN builds the IR-capture counter
// behind FetchCount; without it FetchCount is tied to zero.
module pc_ir_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ReadData1,
  input  logic [31:0] readIns,
  output logic [31:0] InsAddr,
  output logic        InsMemRW,
  output logic [31:0] IR,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  func,
  output logic [15:0] Immediate,
  output logic [31:0] PC4,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {S_RST, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic        insmemrw_q, insmemrw_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_w;
  logic [31:0] next_pc;
  logic        ir_load;
  logic        pc_load;
  logic        halt_cap;
  logic        unused_rd1_lsbs;

  // Word-aligned branch displacement: sign-extended immediate times four.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
    br_offset = {{14{imm[15]}}, imm, 2'b00};
  endfunction

  assign unused_rd1_lsbs = ^ReadData1[1:0];

  // Strobes are only honoured while running; the halt edge still takes PCWre.
  assign ir_load  = (state_q == S_RUN) && IRWre;
  assign pc_load  = (state_q == S_RUN) && PCWre;
  assign halt_cap = ir_load && (readIns[31:26] == HALT_OP);

  assign pc4_w = pc_q + 32'd4;

  // Next-PC selection; branch and jump targets come from the latched IR.
  always_comb begin
    next_pc = pc4_w;
    case (PCSrc)
      2'b00:   next_pc = pc4_w;
      2'b01:   next_pc = pc4_w + $unsigned(br_offset(ir_q[15:0]));
      2'b10:   next_pc = {pc4_w[31:28], ir_q[25:0], 2'b00};
      default: next_pc = {ReadData1[31:2], 2'b00};
    endcase
  end

  // FSM next state; InsMemRW and Halted are registered from the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_RUN;
      S_RUN:   if (halt_cap) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    insmemrw_d = (state_d == S_RUN);
    halted_d   = (state_d == S_HALT);
  end

  // FSM state and its registered outputs.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_RST;
      insmemrw_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      insmemrw_q <= insmemrw_d;
      halted_q   <= halted_d;
    end
  end

  // PC and IR load enables.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (pc_load) pc_d = next_pc;
    if (ir_load) ir_d = readIns;
  end

  // PC and IR registers; PC low bits stay word aligned.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
      ir_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

`ifdef PC_IR_FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count every honoured IR capture, the halt capture included; wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (ir_load) cnt_d = cnt_q + 32'd1;
  end

  // Capture counter register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  assign FetchCount = cnt_q;
`else
  assign FetchCount = 32'd0;
`endif

  assign InsAddr   = pc_q;
  assign InsMemRW  = insmemrw_q;
  assign Halted    = halted_q;
  assign IR        = ir_q;
  assign PC4       = pc4_w;
  assign op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign shamt     = ir_q[10:6];
  assign func      = ir_q[5:0];
  assign Immediate = ir_q[15:0];

endmodule

// File: tb/tb_pc_ir_fetch.sv
// Testbench for pc_ir_fetch: behavioural model feeds a scoreboard queue of
// expected post-edge state, popped and compared one cycle later, plus
// directed constant checks of the documented scenarios.
module tb_pc_ir_fetch;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre, IRWre;
  logic [1:0]  PCSrc;
  logic [31:0] ReadData1, readIns;
  logic [31:0] InsAddr, IR, PC4, FetchCount;
  logic        InsMemRW, Halted;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] Immediate;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] cnt;
    logic        rw;
    logic        hlt;
  } exp_t;

  exp_t sb_q[$];

  // reference model state: 0 = reset, 1 = run, 2 = halt
  logic [31:0] m_pc, m_ir, m_cnt;
  int          m_st;

  pc_ir_fetch dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc),
    .ReadData1(ReadData1), .readIns(readIns), .InsAddr(InsAddr),
    .InsMemRW(InsMemRW), .IR(IR), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .func(func), .Immediate(Immediate), .PC4(PC4),
    .Halted(Halted), .FetchCount(FetchCount)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0000_0000;
    m_ir  = 32'h0;
    m_cnt = 32'h0;
    m_st  = 0;
  endtask

  // Drive one cycle of strobes, push the model's expectation, clock, compare.
  task automatic step(input logic pw, input logic iw, input logic [1:0] src,
                      input logic [31:0] rd1, input logic [31:0] ins);
    exp_t e;
    exp_t got;
    logic [31:0] npc, nir;
    int          nst;
    PCWre = pw; IRWre = iw; PCSrc = src; ReadData1 = rd1; readIns = ins;
    npc = m_pc; nir = m_ir; nst = m_st;
    if (m_st == 0) nst = 1;
    else if (m_st == 1) begin
      if (iw) begin
        nir = ins;
`ifdef PC_IR_FETCH_CNT_EN
        m_cnt = m_cnt + 1;
`endif
        if (ins[31:26] == 6'h3F) nst = 2;
      end
      if (pw) begin
        case (src)
          2'b00: npc = m_pc + 4;
          2'b01: npc = m_pc + 4 + ($signed({{16{m_ir[15]}}, m_ir[15:0]}) * 4);
          2'b10: npc = ((m_pc + 4) & 32'hF000_0000) | ({6'b0, m_ir[25:0]} << 2);
          default: npc = rd1 & ~32'h3;
        endcase
      end
    end
    m_pc = npc; m_ir = nir; m_st = nst;
    e.pc = m_pc; e.ir = m_ir; e.cnt = m_cnt; e.rw = (m_st == 1); e.hlt = (m_st == 2);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    got = sb_q.pop_front();
    check_eq("sb_pc", InsAddr, got.pc);
    check_eq("sb_ir", IR, got.ir);
    check_eq("sb_cnt", FetchCount, got.cnt);
    check_eq("sb_rw", {31'b0, InsMemRW}, {31'b0, got.rw});
    check_eq("sb_halted", {31'b0, Halted}, {31'b0, got.hlt});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; PCWre = 1'b0; IRWre = 1'b0; PCSrc = 2'b00;
    ReadData1 = 32'h0; readIns = 32'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_insaddr", InsAddr, 32'h0);
    check_eq("rst_rw", {31'b0, InsMemRW}, 32'h0);
    check_eq("rst_ir", IR, 32'h0);
    check_eq("rst_pc4", PC4, 32'h4);
    check_eq("rst_halted", {31'b0, Halted}, 32'h0);
    check_eq("rst_cnt", FetchCount, 32'h0);
    Reset = 1'b1;

    // first edge after release: IRWre ignored, now running
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'hDEAD_BEEF);
    check_eq("srst_ir_ignored", IR, 32'h0);
    check_eq("run_rw", {31'b0, InsMemRW}, 32'h1);

    // sequential fetch and decode
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0211_8020);
    check_eq("dec_op", {26'b0, op}, 32'd0);
    check_eq("dec_rs", {27'b0, rs}, 32'd16);
    check_eq("dec_rt", {27'b0, rt}, 32'd17);
    check_eq("dec_rd", {27'b0, rd}, 32'd16);
    check_eq("dec_shamt", {27'b0, shamt}, 32'd0);
    check_eq("dec_func", {26'b0, func}, 32'h20);
    check_eq("dec_imm", {16'b0, Immediate}, 32'h8020);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("seq_pc4", InsAddr, 32'h4);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("seq_pc8", InsAddr, 32'h8);

    // backward branch, imm = -2
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h1000_FFFE);
    step(1'b1, 1'b0, 2'b01, 32'h0, 32'h0);
    check_eq("branch_pc", InsAddr, 32'h4);

    // jump
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0800_0010);
    step(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
    check_eq("jump_pc", InsAddr, 32'h40);

    // register jump with low bits forced clear
    step(1'b1, 1'b0, 2'b11, 32'h0000_0127, 32'h0);
    check_eq("jr_pc", InsAddr, 32'h124);

    // wrap
    step(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0);
    check_eq("wrap_pre", InsAddr, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", PC4, 32'h0);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("wrap_pc", InsAddr, 32'h0);

    // simultaneous strobes
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'h2222_0005);
    check_eq("simul_ir", IR, 32'h2222_0005);
    check_eq("simul_pc", InsAddr, 32'h4);
    // branch target uses latched IR (imm 5), not readIns
    step(1'b1, 1'b1, 2'b01, 32'h0, 32'h1000_FFFF);
    check_eq("br_old_ir", InsAddr, 32'h1C);

    // halt with simultaneous PCWre
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'hFC00_0000);
    check_eq("halt_pc", InsAddr, 32'h20);
    check_eq("halt_ir", IR, 32'hFC00_0000);
    check_eq("halt_flag", {31'b0, Halted}, 32'h1);
    check_eq("halt_rw", {31'b0, InsMemRW}, 32'h0);
    step(1'b1, 1'b1, 2'b01, 32'h0, 32'h0000_1234);
    step(1'b1, 1'b1, 2'b11, 32'h0000_0800, 32'h0000_5678);
    check_eq("halt_frozen_pc", InsAddr, 32'h20);
    check_eq("halt_frozen_ir", IR, 32'hFC00_0000);
`ifdef PC_IR_FETCH_CNT_EN
    check_eq("cnt_total", FetchCount, 32'd6);
`else
    check_eq("cnt_total", FetchCount, 32'd0);
`endif

    // asynchronous reset mid-halt
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pc", InsAddr, 32'h0);
    check_eq("arst_ir", IR, 32'h0);
    check_eq("arst_halted", {31'b0, Halted}, 32'h0);
    check_eq("arst_rw", {31'b0, InsMemRW}, 32'h0);
    check_eq("arst_cnt", FetchCount, 32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'h0211_8020);
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'h0000_0001);
    check_eq("restart_pc", InsAddr, 32'h4);
    check_eq("restart_ir", IR, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
